input_unit: RTL and testbench

- Router input-port stage sitting directly upstream of the switch allocator.
- One instance per input direction (L, E, S, W) of router node (1,0), which has no north port.
- Buffers incoming 40-bit flits in a DEPTH-entry FIFO and computes an XY route at enqueue time.
- Presents the head flit and its one-hot output-request label to the allocator; pops on the allocator's ready pulse.

---
 rtl/router_pkg.sv | 48 ++++
 rtl/input_unit_if.sv | 39 +++
 rtl/xy_route.sv | 38 +++
 rtl/input_unit.sv | 114 +++++++++++
 tb/tb_input_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg: definitions shared by all router input ports.
//   - Flit field offsets for the 40-bit flit:
//     [39:36] src, [35:32] dst, [31:24] timestamp, [23:2] data, [1:0] type.
//   - Label bit indices for the one-hot output request {W,S,E,L}.
//   - Route enum, including the N_ILLEGAL direction for the missing north port.
//   - A helper function that converts a route into its one-hot label.
package router_pkg;

  localparam int SRC_HI  = 39;
  localparam int SRC_LO  = 36;
  localparam int DST_HI  = 35;
  localparam int DST_LO  = 32;
  localparam int TS_HI   = 31;
  localparam int TS_LO   = 24;
  localparam int DATA_HI = 23;
  localparam int DATA_LO = 2;
  localparam int TYPE_HI = 1;
  localparam int TYPE_LO = 0;

  localparam int LBL_L   = 0;
  localparam int LBL_E   = 1;
  localparam int LBL_S   = 2;
  localparam int LBL_W   = 3;
  localparam int LABEL_W = 4;

  typedef enum logic [2:0] {
    ROUTE_L   = 3'd0,
    ROUTE_E   = 3'd1,
    ROUTE_S   = 3'd2,
    ROUTE_W   = 3'd3,
    N_ILLEGAL = 3'd4
  } route_e;

  // N_ILLEGAL maps to an all-zero label: it never reaches the allocator.
  function automatic logic [LABEL_W-1:0] route_to_label(input route_e r);
    logic [LABEL_W-1:0] lbl;
    lbl = '0;
    case (r)
      ROUTE_L: lbl[LBL_L] = 1'b1;
      ROUTE_E: lbl[LBL_E] = 1'b1;
      ROUTE_S: lbl[LBL_S] = 1'b1;
      ROUTE_W: lbl[LBL_W] = 1'b1;
      default: lbl = '0;
    endcase
    return lbl;
  endfunction

endpackage

// File: rtl/input_unit_if.sv
// input_unit_if: the bus between the upstream link, an input_unit, and the
// switch allocator.
//   Upstream side : data_in, valid_in (into the unit), full (out of the unit).
//   Allocator side: data_out, label, ready (into the unit), count, route_err,
//                   drop_cnt.
//
// Handshake rules:
//   - Upstream: a flit moves when valid_in is high in a cycle where full is
//     low. Upstream must hold valid_in low while full is high. If it does
//     not, the flit is ignored.
//   - Allocator: data_out and label describe the head flit whenever label is
//     non-zero. ready is a one-cycle grant that pops the head flit. ready
//     while the unit is empty has no effect.
//
// Modports: master = the driving environment, slave = the input_unit.
interface input_unit_if #(
  parameter int DATASIZE = 40,
  parameter int WIDTH    = 3
);
  logic [DATASIZE-1:0] data_in;
  logic                valid_in;
  logic                full;
  logic [3:0]          label;
  logic [DATASIZE-1:0] data_out;
  logic                ready;
  logic [WIDTH:0]      count;
  logic                route_err;
  logic [7:0]          drop_cnt;

  modport master (
    output data_in, valid_in, ready,
    input  full, label, data_out, count, route_err, drop_cnt
  );

  modport slave (
    input  data_in, valid_in, ready,
    output full, label, data_out, count, route_err, drop_cnt
  );
endinterface

// File: rtl/xy_route.sv
// xy_route: combinational dimension-ordered (X first, then Y) routing.
// Every input_unit instance of a node uses this module.
//   dst      : destination {y[1:0], x[1:0]} taken from the flit.
//   local_x  : this node's x coordinate.
//   local_y  : this node's y coordinate.
//   label    : one-hot output request {W,S,E,L}. It is zero for north.
//   is_north : the flit would need to leave through the north port, which
//              this node does not have.
module xy_route
  import router_pkg::*;
(
  input  logic [3:0] dst,
  input  logic [1:0] local_x,
  input  logic [1:0] local_y,
  output logic [3:0] label,
  output logic       is_north
);

  logic [1:0] dst_x;
  logic [1:0] dst_y;
  route_e     route;

  assign dst_x = dst[1:0];
  assign dst_y = dst[3:2];

  always_comb begin
    route = ROUTE_L;
    if (dst_x > local_x)      route = ROUTE_E;
    else if (dst_x < local_x) route = ROUTE_W;
    else if (dst_y > local_y) route = ROUTE_S;
    else if (dst_y < local_y) route = N_ILLEGAL;
    else                      route = ROUTE_L;
  end

  assign label    = route_to_label(route);
  assign is_north = (route == N_ILLEGAL);

endmodule

// File: rtl/input_unit.sv
// input_unit: router input-port stage feeding the switch allocator.
// The unit routes each flit when it is written, then holds the flit together
// with its one-hot label in a DEPTH-entry FIFO. The head entry is presented
// to the allocator, and the unit pops it when ready is asserted.
// Ports:
//   clk, rst : clock and asynchronous active-high reset.
//   bus      : input_unit_if.slave. It carries data_in, valid_in, full,
//              data_out, label, ready, count, route_err and drop_cnt.
// A flit that would route north is never stored. Instead it raises
// route_err for one cycle and bumps the saturating drop_cnt.
module input_unit
  import router_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         WIDTH    = 3,
  parameter int         DATASIZE = 40,
  parameter logic [1:0] LOCAL_X  = 2'd1,
  parameter logic [1:0] LOCAL_Y  = 2'd0
)(
  input  logic         clk,
  input  logic         rst,
  input_unit_if.slave  bus
);

  localparam int             SW      = DATASIZE + LABEL_W;
  localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);

  logic [SW-1:0]    mem_q [DEPTH];
  logic [SW-1:0]    mem_d [DEPTH];
  logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]   count_q, count_d;
  logic             route_err_q, route_err_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [3:0]       in_label;
  logic             in_north;
  logic             full_w;
  logic             push;
  logic             pop;
  logic             drop;
  logic [SW-1:0]    head;

  xy_route u_route (
    .dst      (bus.data_in[DST_HI:DST_LO]),
    .local_x  (LOCAL_X),
    .local_y  (LOCAL_Y),
    .label    (in_label),
    .is_north (in_north)
  );

  // full comes from the registered count. A pop therefore frees a slot only
  // from the following cycle, and a push in the same cycle as that pop is
  // still rejected.
  assign full_w = (count_q == DEPTH_C);
  assign push   = bus.valid_in & ~full_w & ~in_north;
  assign drop   = bus.valid_in & ~full_w &  in_north;
  assign pop    = bus.ready & (count_q != '0);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    route_err_d = drop;
    drop_cnt_d  = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_label, bus.data_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      route_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      route_err_q <= route_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // The label is masked while empty. This stops the allocator from acting on
  // a stale slot. data_out is not masked and simply shows whatever the read
  // pointer addresses.
  assign head          = mem_q[rd_ptr_q];
  assign bus.data_out  = head[DATASIZE-1:0];
  assign bus.label     = (count_q == '0) ? 4'b0000 : head[SW-1:DATASIZE];
  assign bus.full      = full_w;
  assign bus.count     = count_q;
  assign bus.route_err = route_err_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_input_unit.sv
// tb_input_unit: self-checking bench for input_unit.
// Two instances are used:
//   u_dut0 at node (1,0). It has no north port, so every flit is legal.
//   u_dut1 at (1,1). A destination of (1,0) routes north there and is dropped.
module tb_input_unit;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [43:0] exp_q[$];

  typedef struct {
    logic [3:0] dst;
    logic [3:0] exp_label;
  } vec_t;

  vec_t vecs[8];

  input_unit_if #(.DATASIZE(40), .WIDTH(3)) if0 ();
  input_unit_if #(.DATASIZE(40), .WIDTH(3)) if1 ();

  input_unit #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOCAL_X(2'd1), .LOCAL_Y(2'd0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  input_unit #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOCAL_X(2'd1), .LOCAL_Y(2'd1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference router. Bit 4 flags north, bits 3:0 are {W,S,E,L}.
  function automatic logic [4:0] exp_route(input logic [3:0] dst,
                                           input logic [1:0] lx,
                                           input logic [1:0] ly);
    if (dst[1:0] != lx) return (dst[1:0] > lx) ? 5'b00010 : 5'b01000;
    if (dst[3:2] == ly) return 5'b00001;
    return (dst[3:2] > ly) ? 5'b00100 : 5'b10000;
  endfunction

  function automatic logic [39:0] mk_flit(input logic [3:0] dst);
    return {4'($urandom_range(0, 15)), dst, 8'($urandom_range(0, 255)),
            22'($urandom), 2'($urandom_range(0, 3))};
  endfunction

  // ---------------- drivers ----------------
  // One cycle on u_dut0, checked against the scoreboard.
  task automatic step(input logic v, input logic [39:0] d, input logic r);
    logic [4:0]  rt;
    logic        push_ok;
    logic        pop_ok;
    logic [43:0] head;
    rt      = exp_route(d[35:32], 2'd1, 2'd0);
    push_ok = v && (exp_q.size() < 8) && !rt[4];
    pop_ok  = r && (exp_q.size() != 0);
    if (pop_ok) begin
      head = exp_q.pop_front();
      chk("pop_data", {24'd0, if0.data_out}, {24'd0, head[39:0]});
      chk("pop_label", {60'd0, if0.label}, {60'd0, head[43:40]});
    end
    if (push_ok) exp_q.push_back({rt[3:0], d});
    if0.valid_in = v;
    if0.data_in  = d;
    if0.ready    = r;
    @(posedge clk);
    #1;
    if0.valid_in = 1'b0;
    if0.ready    = 1'b0;
    chk("count", {60'd0, if0.count}, 64'(exp_q.size()));
    chk("full", {63'd0, if0.full}, {63'd0, exp_q.size() == 8});
    chk("label", {60'd0, if0.label},
        (exp_q.size() == 0) ? 64'd0 : {60'd0, exp_q[0][43:40]});
    if (exp_q.size() != 0)
      chk("head_data", {24'd0, if0.data_out}, {24'd0, exp_q[0][39:0]});
  endtask

  // One cycle on u_dut1. Its callers do the checks.
  task automatic step1(input logic v, input logic [39:0] d, input logic r);
    if1.valid_in = v;
    if1.data_in  = d;
    if1.ready    = r;
    @(posedge clk);
    #1;
    if1.valid_in = 1'b0;
    if1.ready    = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [39:0] f;
    logic [39:0] legal1;
    logic [39:0] north1;

    vecs[0] = '{dst: 4'b0011, exp_label: 4'b0010};  // x=3      -> E
    vecs[1] = '{dst: 4'b0000, exp_label: 4'b1000};  // x=0      -> W
    vecs[2] = '{dst: 4'b1001, exp_label: 4'b0100};  // x=1,y=2  -> S
    vecs[3] = '{dst: 4'b0001, exp_label: 4'b0001};  // x=1,y=0  -> L
    vecs[4] = '{dst: 4'b0010, exp_label: 4'b0010};  // x=2      -> E
    vecs[5] = '{dst: 4'b1100, exp_label: 4'b1000};  // x=0,y=3  -> W
    vecs[6] = '{dst: 4'b0101, exp_label: 4'b0100};  // x=1,y=1  -> S
    vecs[7] = '{dst: 4'b1111, exp_label: 4'b0010};  // x=3,y=3  -> E

    if0.valid_in = 1'b0; if0.ready = 1'b0; if0.data_in = '0;
    if1.valid_in = 1'b0; if1.ready = 1'b0; if1.data_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_count", {60'd0, if0.count}, 64'd0);
    chk("rst_label", {60'd0, if0.label}, 64'd0);
    chk("rst_full", {63'd0, if0.full}, 64'd0);
    chk("rst_drop", {56'd0, if0.drop_cnt}, 64'd0);
    chk("rst_data", {24'd0, if0.data_out}, 64'd0);
    chk("rst_err", {63'd0, if0.route_err}, 64'd0);
    chk("rst_count1", {60'd0, if1.count}, 64'd0);
    chk("rst_drop1", {56'd0, if1.drop_cnt}, 64'd0);

    // Single push/pop for each route in the table.
    for (int i = 0; i < 8; i++) begin
      f = mk_flit(vecs[i].dst);
      step(1'b1, f, 1'b0);
      chk("tbl_label", {60'd0, if0.label}, {60'd0, vecs[i].exp_label});
      chk("tbl_data", {24'd0, if0.data_out}, {24'd0, f});
      step(1'b0, '0, 1'b1);
      chk("tbl_empty_label", {60'd0, if0.label}, 64'd0);
    end

    // Back-to-back W, S, L pushes, then one pop per cycle.
    step(1'b1, mk_flit(4'b0000), 1'b0);
    step(1'b1, mk_flit(4'b1001), 1'b0);
    step(1'b1, mk_flit(4'b0001), 1'b0);
    chk("seq_w", {60'd0, if0.label}, 64'b1000);
    step(1'b0, '0, 1'b1);
    chk("seq_s", {60'd0, if0.label}, 64'b0100);
    step(1'b0, '0, 1'b1);
    chk("seq_l", {60'd0, if0.label}, 64'b0001);
    step(1'b0, '0, 1'b1);

    // Fill to full, push while full, then push and pop in the same cycle.
    for (int i = 0; i < 8; i++) step(1'b1, mk_flit(4'($urandom_range(0, 15))), 1'b0);
    chk("fill_full", {63'd0, if0.full}, 64'd1);
    chk("fill_count", {60'd0, if0.count}, 64'd8);
    step(1'b1, mk_flit(4'b0011), 1'b0);
    chk("ninth_ignored", {60'd0, if0.count}, 64'd8);
    if0.valid_in = 1'b1;
    if0.ready    = 1'b1;
    chk("full_pp_same", {60'd0, if0.count}, 64'd8);
    step(1'b1, mk_flit(4'b0000), 1'b1);
    chk("full_pp_next", {60'd0, if0.count}, 64'd7);

    // Random traffic against the scoreboard, then drain.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), mk_flit(4'($urandom_range(0, 15))),
           1'($urandom_range(0, 1)));
    repeat (8) step(1'b0, '0, 1'b1);
    chk("drained", {60'd0, if0.count}, 64'd0);

    // North drops on the (1,1) instance.
    north1 = mk_flit(4'b0001);
    legal1 = mk_flit(4'b0101);
    step1(1'b1, north1, 1'b0);
    chk("drop_err", {63'd0, if1.route_err}, 64'd1);
    chk("drop_cnt1", {56'd0, if1.drop_cnt}, 64'd1);
    chk("drop_nostore", {60'd0, if1.count}, 64'd0);
    step1(1'b0, '0, 1'b0);
    chk("drop_err_pulse", {63'd0, if1.route_err}, 64'd0);
    step1(1'b1, legal1, 1'b0);
    chk("u1_label", {60'd0, if1.label}, 64'b0001);
    chk("u1_data", {24'd0, if1.data_out}, {24'd0, legal1});
    step1(1'b0, '0, 1'b1);
    chk("u1_pop", {60'd0, if1.count}, 64'd0);
    for (int i = 0; i < 8; i++) step1(1'b1, legal1, 1'b0);
    chk("u1_full", {63'd0, if1.full}, 64'd1);
    step1(1'b1, north1, 1'b0);
    chk("full_north_nodrop", {56'd0, if1.drop_cnt}, 64'd1);
    chk("full_north_noerr", {63'd0, if1.route_err}, 64'd0);
    repeat (8) step1(1'b0, '0, 1'b1);
    chk("u1_drained", {60'd0, if1.count}, 64'd0);
    for (int i = 0; i < 300; i++) begin
      step1(1'b1, north1, 1'b0);
      chk("drop_sat", {56'd0, if1.drop_cnt}, (i + 2 > 255) ? 64'd255 : 64'(i + 2));
    end
    chk("drop_err_stream", {63'd0, if1.route_err}, 64'd1);
    step1(1'b0, '0, 1'b0);
    chk("drop_err_end", {63'd0, if1.route_err}, 64'd0);

    // Asynchronous reset with 5 flits stored.
    for (int i = 0; i < 5; i++) step(1'b1, mk_flit(4'($urandom_range(0, 15))), 1'b0);
    chk("pre_rst_count", {60'd0, if0.count}, 64'd5);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_count", {60'd0, if0.count}, 64'd0);
    chk("async_rst_label", {60'd0, if0.label}, 64'd0);
    chk("async_rst_drop1", {56'd0, if1.drop_cnt}, 64'd0);
    exp_q.delete();
    #2;
    rst = 1'b0;
    f = mk_flit(4'b1001);
    step(1'b1, f, 1'b0);
    chk("post_rst_data", {24'd0, if0.data_out}, {24'd0, f});
    step(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
